// File: rtl/skid_buf.sv
// skid_buf: two-entry skid buffer between a valid/ready producer and consumer.
//   clk       rising-edge clock
//   reset     asynchronous, active-high reset
//   flush     synchronous discard of all held entries
//   in_valid  producer presents in_data
//   in_data   producer payload (WIDTH bits)
//   in_ready  block can accept an entry this cycle (from state only)
//   out_valid out_data holds a valid entry (from state only)
//   out_data  oldest held payload (main register)
//   out_ready consumer takes out_data this cycle
//   count     number of held entries, 0..2
module skid_buf #(
  parameter int unsigned WIDTH = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [1:0]       count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] main_q, main_nx;
  logic [WIDTH-1:0] skid_q, skid_nx;
  logic             push, pop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      state  <= state_nx;
      main_q <= main_nx;
      skid_q <= skid_nx;
    end
  end

  // Handshake signals depend on registered state only, so there is no
  // combinational path between the producer and consumer sides.
  assign in_ready  = (state != FULL) && !reset;
  assign out_valid = (state != EMPTY);
  assign out_data  = main_q;

  always_comb begin
    push     = in_valid && in_ready;
    pop      = out_valid && out_ready;
    state_nx = state;
    main_nx  = main_q;
    skid_nx  = skid_q;
    if (flush) begin
      // Flush drops everything, including any same-cycle push; the data
      // registers keep their contents.
      state_nx = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (push) begin
            state_nx = ONE;
            main_nx  = in_data;
          end
        end
        ONE: begin
          if (push && pop) begin
            main_nx = in_data;
          end else if (push) begin
            state_nx = FULL;
            skid_nx  = in_data;
          end else if (pop) begin
            state_nx = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            state_nx = ONE;
            main_nx  = skid_q;
          end
        end
        default: state_nx = EMPTY;
      endcase
    end
  end

  always_comb begin
    count = 2'd0;
    case (state)
      EMPTY:   count = 2'd0;
      ONE:     count = 2'd1;
      FULL:    count = 2'd2;
      default: count = 2'd0;
    endcase
  end

endmodule

// File: tb/tb_skid_buf.sv
module tb_skid_buf;

  localparam int unsigned WIDTH = 9;

  logic             clk = 1'b0;
  logic             reset;
  logic             flush;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic [1:0]       count;

  int total = 0;
  int bad   = 0;

  // Reference model: ordered list of held payloads plus the last value
  // presented on out_data.
  logic [WIDTH-1:0] q[$];
  logic [WIDTH-1:0] last_out = '0;

  always #5 clk = ~clk;

  skid_buf #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .count     (count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_model();
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    chk("count",     32'(count),     32'(q.size()));
    chk("in_ready",  32'(in_ready),  32'((q.size() < 2) && !reset));
    chk("out_data",  32'(out_data),  32'(last_out));
  endtask

  // One clock: decide handshakes from the model before the edge, apply
  // them at the edge, then compare shortly after.
  task automatic cyc();
    bit push, pop;
    logic [WIDTH-1:0] d;
    push = (in_valid === 1'b1) && (q.size() < 2) && !reset;
    pop  = (q.size() > 0) && (out_ready === 1'b1);
    d    = in_data;
    @(posedge clk);
    if (reset) begin
      q.delete();
      last_out = '0;
    end else if (flush) begin
      q.delete();
    end else begin
      if (pop)  void'(q.pop_front());
      if (push) q.push_back(d);
    end
    if (q.size() > 0) last_out = q[0];
    #1;
    check_model();
  endtask

  task automatic idle();
    flush = 0; in_valid = 0; out_ready = 0; in_data = '0;
  endtask

  initial begin
    reset = 1; idle();
    #2;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_count",     32'(count), 0);
    chk("rst_in_ready",  32'(in_ready), 0);
    chk("rst_out_data",  32'(out_data), 0);
    cyc(); cyc();
    reset = 0;
    #1;
    chk("rel_in_ready", 32'(in_ready), 1);

    // Single push, latency one.
    in_valid = 1; in_data = 9'h0A5; cyc();
    chk("p1_out_data", 32'(out_data), 32'h0A5);
    chk("p1_count", 32'(count), 1);
    idle(); out_ready = 1; cyc(); idle();
    chk("p1_held", 32'(out_data), 32'h0A5);

    // Fill to FULL, extra input ignored, drain in order.
    in_valid = 1; in_data = 9'h001; cyc();
    in_data = 9'h002; cyc();
    chk("full_count", 32'(count), 2);
    chk("full_in_ready", 32'(in_ready), 0);
    in_data = 9'h003; cyc(); cyc();
    in_valid = 0; out_ready = 1;
    cyc();
    chk("drain_2nd", 32'(out_data), 32'h002);
    cyc();
    chk("drain_empty", 32'(count), 0);
    idle();

    // Streaming 0..15.
    in_valid = 1; out_ready = 1;
    for (int i = 0; i < 16; i++) begin
      in_data = WIDTH'(i);
      cyc();
      chk("stream_data", 32'(out_data), 32'(i));
      chk("stream_count", 32'(count), 1);
    end
    idle(); out_ready = 1; cyc(); idle();

    // Flush from FULL with a same-cycle push.
    in_valid = 1; in_data = 9'h100; cyc();
    in_data = 9'h101; cyc();
    flush = 1; in_data = 9'h1FF; cyc();
    chk("flush_count", 32'(count), 0);
    chk("flush_valid", 32'(out_valid), 0);
    idle(); out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      total++;
      assert (out_data !== 9'h1FF) else begin
        bad++;
        $error("FAIL flush_leak observed=%0h expected=not 1ff", out_data);
      end
    end
    idle();

    // Asynchronous reset while FULL, between edges.
    in_valid = 1; in_data = 9'h044; cyc();
    in_data = 9'h055; cyc();
    idle();
    #2 reset = 1;
    #1;
    chk("areset_valid", 32'(out_valid), 0);
    chk("areset_count", 32'(count), 0);
    chk("areset_data",  32'(out_data), 0);
    q.delete(); last_out = '0;
    cyc();
    #2 reset = 0;
    #1;
    chk("arel_in_ready", 32'(in_ready), 1);
    in_valid = 1; in_data = 9'h033; cyc();
    chk("arel_data", 32'(out_data), 32'h033);
    idle(); out_ready = 1; cyc(); idle();

    // Randomized traffic against the model.
    for (int i = 0; i < 10000; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = in_valid ? WIDTH'($urandom) : 'x;
      out_ready = 1'($urandom_range(0, 1));
      flush     = ($urandom_range(0, 31) == 0);
      cyc();
    end
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
